// File: rtl/dsss_spreader.sv
// Direct-sequence spread-spectrum transmitter: each accepted data bit is spread over one
// full LFSR code period. Define DSSS_SPREADER_PREAMBLE_EN for an unmodulated code preamble.
module dsss_spreader #(
    parameter int                LFSR_W        = 8,
    parameter logic [LFSR_W-1:0] TAPS          = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED          = 8'h01,
    parameter int                CODE_LEN      = 255,
    parameter int                CHIP_DIV      = 4,
    parameter int                PREAMBLE_BITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic data_valid,
    input  logic data_bit,
    output logic data_ready,
    output logic code,
    output logic sig,
    output logic bit_start,
    output logic busy
);

    localparam int CHIP_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int DIV_W  = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CODE_LEN - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CHIP_DIV - 1);

    // Parameter sanity: an all-zero seed would lock the LFSR at zero.
    if (SEED == '0 || CODE_LEN < 2 || CHIP_DIV < 1 || PREAMBLE_BITS < 0) begin : g_bad_param
        $error("dsss_spreader: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1
`ifdef DSSS_SPREADER_PREAMBLE_EN
        , ST_PREAMBLE = 2'd2
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CHIP_W-1:0]   chip_q, chip_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                bit_q, bit_d;
    logic                code_q, code_d;
    logic                sig_q, sig_d;
    logic                bit_start_q, bit_start_d;
`ifdef DSSS_SPREADER_PREAMBLE_EN
    localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
`endif

    logic              period_end;
    logic              xfer;
    logic [LFSR_W-1:0] lfsr_next;

    assign period_end = (chip_q == CHIP_LAST) && (div_q == DIV_LAST);
    assign xfer       = data_valid && data_ready;
    assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            chip_q      <= '0;
            div_q       <= '0;
            bit_q       <= 1'b0;
            code_q      <= 1'b0;
            sig_q       <= 1'b0;
            bit_start_q <= 1'b0;
`ifdef DSSS_SPREADER_PREAMBLE_EN
            pre_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            chip_q      <= chip_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            code_q      <= code_d;
            sig_q       <= sig_d;
            bit_start_q <= bit_start_d;
`ifdef DSSS_SPREADER_PREAMBLE_EN
            pre_cnt_q   <= pre_cnt_d;
`endif
        end
    end

    // Next-state: divider -> chip counter -> period boundary, all frozen while en is low.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        chip_d  = chip_q;
        div_d   = div_q;
        bit_d   = bit_q;
`ifdef DSSS_SPREADER_PREAMBLE_EN
        pre_cnt_d = pre_cnt_q;
`endif
        if (xfer) begin
            bit_d = data_bit;
        end
        if (en) begin
            if (state_q == ST_IDLE) begin
                if (xfer) begin
`ifdef DSSS_SPREADER_PREAMBLE_EN
                    state_d   = (PREAMBLE_BITS > 0) ? ST_PREAMBLE : ST_SEND;
                    pre_cnt_d = '0;
`else
                    state_d   = ST_SEND;
`endif
                    lfsr_d = SEED;
                    chip_d = '0;
                    div_d  = '0;
                end
            end else if (div_q != DIV_LAST) begin
                div_d = div_q + 1'b1;
            end else if (chip_q != CHIP_LAST) begin
                div_d  = '0;
                chip_d = chip_q + 1'b1;
                lfsr_d = lfsr_next;
            end else begin
                div_d  = '0;
                chip_d = '0;
                lfsr_d = SEED;
`ifdef DSSS_SPREADER_PREAMBLE_EN
                if (state_q == ST_PREAMBLE) begin
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d = ST_SEND;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end else if (!xfer) begin
                    state_d = ST_IDLE;
                end
`else
                if (!xfer) begin
                    state_d = ST_IDLE;
                end
`endif
            end
        end
    end

    // Outputs: registered chip/spread/pulse lag the counters by one clk.
    always_comb begin
        code_d      = code_q;
        sig_d       = sig_q;
        bit_start_d = bit_start_q;
        data_ready  = rst_n && en &&
                      ((state_q == ST_IDLE) || ((state_q == ST_SEND) && period_end));
        if (en) begin
            if (state_q == ST_IDLE) begin
                code_d      = 1'b0;
                sig_d       = 1'b0;
                bit_start_d = 1'b0;
            end else begin
                code_d      = lfsr_q[0];
                sig_d       = lfsr_q[0] ^ (bit_q && (state_q == ST_SEND));
                bit_start_d = (chip_q == '0) && (div_q == '0);
            end
        end
    end

    assign code      = code_q;
    assign sig       = sig_q;
    assign bit_start = bit_start_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
